// File: rtl/theta_col_seq.sv
// Column-parity sequencer: walks the 25 lanes of a 5x5 state through a granted
// read port and accumulates C[x] = XOR over y of lane(x,y).
module theta_col_seq #(
  parameter int LANE_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_rd_en,
  output logic [4:0]        o_rd_addr,
  input  logic              i_rd_gnt,
  input  logic [LANE_W-1:0] i_rd_data,
  output logic [LANE_W-1:0] o_C [0:4]
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [2:0]        col_q, col_d;
  logic              acc_q, acc_d;
  logic [2:0]        acc_col_q, acc_col_d;
  logic [LANE_W-1:0] c_q [0:4];
  logic [LANE_W-1:0] c_d [0:4];
  logic              rd_fire;

  assign rd_fire = (state_q == READ) && i_rd_gnt;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    col_d     = col_q;
    acc_d     = rd_fire;
    acc_col_d = col_q;
    c_d       = c_q;

    // Lane data arrives one cycle after its accepted read; fold it into its column.
    for (int unsigned x = 0; x < 5; x++) begin
      if (acc_q && (acc_col_q == 3'(x))) begin
        c_d[x] = c_q[x] ^ i_rd_data;
      end
    end

    case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d = READ;
          cnt_d   = '0;
          col_d   = '0;
          for (int unsigned x = 0; x < 5; x++) begin
            c_d[x] = '0;
          end
        end
      end
      READ: begin
        if (i_rd_gnt) begin
          if (cnt_q == 5'd24) begin
            cnt_d   = '0;
            col_d   = '0;
            state_d = DRAIN;
          end else begin
            cnt_d = cnt_q + 5'd1;
            col_d = (col_q == 3'd4) ? 3'd0 : col_q + 3'd1;
          end
        end
      end
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      col_q     <= '0;
      acc_q     <= 1'b0;
      acc_col_q <= '0;
      for (int unsigned x = 0; x < 5; x++) begin
        c_q[x] <= '0;
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      col_q     <= col_d;
      acc_q     <= acc_d;
      acc_col_q <= acc_col_d;
      for (int unsigned x = 0; x < 5; x++) begin
        c_q[x] <= c_d[x];
      end
    end
  end

  assign o_busy    = (state_q != IDLE);
  assign o_done    = (state_q == DONE);
  assign o_rd_en   = (state_q == READ);
  assign o_rd_addr = cnt_q;
  assign o_C       = c_q;

endmodule

// File: tb/tb_theta_col_seq.sv
// Randomized bench for theta_col_seq: a lane memory model answers granted reads,
// and column parities / done latency are predicted from the lane contents.
module tb_theta_col_seq;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_start;
  logic        o_busy, o_done, o_rd_en;
  logic [4:0]  o_rd_addr;
  logic        i_rd_gnt;
  logic [31:0] i_rd_data;
  logic [31:0] c [0:4];

  logic [31:0] mem [0:24];
  int          n_checks = 0;
  int          n_fail   = 0;

  theta_col_seq #(.LANE_W(32)) dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_start   (i_start),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_rd_en   (o_rd_en),
    .o_rd_addr (o_rd_addr),
    .i_rd_gnt  (i_rd_gnt),
    .i_rd_data (i_rd_data),
    .o_C       (c)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 64'(o_busy), 64'd0);
    check({tag, "_done"}, 64'(o_done), 64'd0);
    check({tag, "_rd_en"}, 64'(o_rd_en), 64'd0);
    check({tag, "_rd_addr"}, 64'(o_rd_addr), 64'd0);
    for (int x = 0; x < 5; x++) check($sformatf("%s_C%0d", tag, x), 64'(c[x]), 64'd0);
  endtask

  task automatic pulse_reset(input string tag);
    i_rst_n = 1'b0;
    i_start = 1'b0;
    #1;
    check_reset_outputs(tag);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      check({tag, "_idle_busy"}, 64'(o_busy), 64'd0);
      check({tag, "_idle_done"}, 64'(o_done), 64'd0);
    end
  endtask

  // gmode: 0 grant high, 1 grant toggles per READ cycle, 2 random grant
  // dmode: 0 lane=1<<y, 1 lane=addr, 2 all ones, 3 all zeros, 4 random
  task automatic run(input int gmode, input int dmode, input bit hold, input int abort_at);
    logic [31:0] expc [0:4];
    int  lows = 0;
    int  nacc = 0;
    int  rdcyc = 0;
    bit  pend = 1'b0;
    int  paddr = 0;
    bit  done_seen = 1'b0;
    bit  gnt;

    for (int a = 0; a < 25; a++) begin
      case (dmode)
        0:       mem[a] = 32'd1 << (a / 5);
        1:       mem[a] = 32'(a);
        2:       mem[a] = 32'hFFFF_FFFF;
        3:       mem[a] = 32'h0;
        default: mem[a] = $urandom;
      endcase
    end
    for (int x = 0; x < 5; x++) begin
      expc[x] = 32'h0;
      for (int y = 0; y < 5; y++) expc[x] = expc[x] ^ mem[5 * y + x];
    end

    @(negedge i_clk);
    i_start = 1'b1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge i_clk);
      if (!hold) i_start = 1'b0;
      if (abort_at >= 0 && pend && paddr == abort_at) begin
        pulse_reset("abort");
        return;
      end
      if (k == 1) check("c_cleared_at_start", 64'(c[0] | c[1] | c[2] | c[3] | c[4]), 64'd0);
      i_rd_data = pend ? mem[paddr] : 32'hDEAD_BEEF;
      if (o_done) begin
        check("done_cycle", 64'(k), 64'(27 + lows));
        for (int x = 0; x < 5; x++) check($sformatf("C%0d", x), 64'(c[x]), 64'(expc[x]));
        done_seen = 1'b1;
        break;
      end
      check("busy_in_run", 64'(o_busy), 64'd1);
      case (gmode)
        0:       gnt = 1'b1;
        1:       gnt = (rdcyc % 2 == 0);
        default: gnt = 1'($urandom_range(0, 1));
      endcase
      i_rd_gnt = gnt;
      if (o_rd_en) begin
        if (gnt) begin
          check("rd_addr_order", 64'(o_rd_addr), 64'(nacc));
          nacc++;
        end else begin
          lows++;
        end
        rdcyc++;
      end
      pend  = o_rd_en && gnt;
      paddr = int'(o_rd_addr);
    end
    check("done_seen", 64'(done_seen), 64'd1);
    check("accepted_reads", 64'(nacc), 64'd25);

    @(negedge i_clk);
    i_rd_data = 32'hDEAD_BEEF;
    check("done_one_cycle", 64'(o_done), 64'd0);
    check("idle_after_done", 64'(o_busy), 64'd0);
    if (hold) begin
      @(negedge i_clk);
      check("restart_busy", 64'(o_busy), 64'd1);
      check("restart_rd_en", 64'(o_rd_en), 64'd1);
      check("restart_addr", 64'(o_rd_addr), 64'd0);
      pulse_reset("hold_cleanup");
    end else begin
      for (int x = 0; x < 5; x++) check($sformatf("C%0d_hold", x), 64'(c[x]), 64'(expc[x]));
    end
  endtask

  initial begin
    i_rst_n   = 1'b0;
    i_start   = 1'b0;
    i_rd_gnt  = 1'b0;
    i_rd_data = 32'hDEAD_BEEF;
    #1;
    check_reset_outputs("reset");
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    check("idle_no_start", 64'(o_busy), 64'd0);

    run(0, 0, 1'b0, -1);
    run(1, 1, 1'b0, -1);
    run(0, 2, 1'b0, -1);
    run(0, 3, 1'b0, -1);
    run(2, 4, 1'b1, -1);
    run(2, 4, 1'b0, 12);
    run(2, 4, 1'b0, -1);
    for (int r = 0; r < 4; r++) run(2, 4, 1'b0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/theta_col_seq.md
THETA_COL_SEQ -- requirements
Module: theta_col_seq

Interface
REQ-001 SHALL have parameter LANE_W, default 32, giving the lane width in bits.
REQ-002 SHALL have port i_clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port i_rst_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port i_start, input, 1: request to compute the column parities of one 5x5 lane state.
REQ-005 SHALL have port o_busy, output, 1: high in every state except IDLE.
REQ-006 SHALL have port o_done, output, 1: one-cycle pulse marking o_C valid.
REQ-007 SHALL have port o_rd_en, output, 1: lane read request to the shared state memory.
REQ-008 SHALL have port o_rd_addr, output, 5: lane address = 5*y + x, range 0..24.
REQ-009 SHALL have port i_rd_gnt, input, 1: memory grant; a read is accepted on an edge where o_rd_en and i_rd_gnt are both high.
REQ-010 SHALL have port i_rd_data, input, LANE_W: lane data, valid in the cycle after an accepted read.
REQ-011 SHALL have port o_C, output, array [0:4] of LANE_W: column parity C[x] = XOR over y=0..4 of lane(x,y).

Function
REQ-012 SHALL implement the FSM states IDLE, READ, DRAIN and DONE.
REQ-013 SHALL, in IDLE with i_start high, clear all o_C to 0, clear the address counter, and go to READ; i_start SHALL be ignored in all other states.
REQ-014 SHALL, in READ, drive o_rd_en=1 and o_rd_addr=counter; it SHALL drive o_rd_en=0 in all other states.
REQ-015 SHALL increment the counter only on an accepted read; with i_rd_gnt low, o_rd_addr SHALL hold its value and no data is expected.
REQ-016 SHALL issue reads in ascending order 0..24, each address exactly once per run.
REQ-017 SHALL leave READ for DRAIN on the edge that accepts address 24.
REQ-018 SHALL register an accept flag and the column index x = addr mod 5; on the next edge, when the flag is set, o_C[x] <= o_C[x] XOR i_rd_data.
REQ-019 SHALL ignore i_rd_data in every cycle that does not follow an accepted read.
REQ-020 SHALL spend exactly one cycle in DRAIN, capture the last lane there, then go to DONE.
REQ-021 SHALL assert o_done for exactly one cycle in DONE, then return to IDLE.
REQ-022 SHALL give o_C final values in the DONE cycle and hold them until the next accepted i_start.
REQ-023 SHALL, with i_rd_gnt held high, assert o_done in the 27th cycle after the edge that samples i_start; each grant-low cycle in READ adds one cycle.
REQ-024 SHALL perform all XORs bitwise at LANE_W width, with no carry and no truncation.
REQ-025 SHALL not accept a new i_start in the DONE cycle; a start in the following IDLE cycle SHALL be accepted.

Reset
REQ-026 SHALL, while i_rst_n is low, force state=IDLE, counter=0, accept flag=0, o_C=0, o_busy=0, o_done=0, o_rd_en=0 and o_rd_addr=0, independent of i_clk.
REQ-027 SHALL abort any run on reset mid-operation with no o_done pulse; after reset release the block SHALL idle until a new i_start.

Verification
REQ-028 SHALL pass: lane(x,y) = 1<<y, grant always high, start pulse -> addresses 0..24 in consecutive cycles, o_done in the 27th cycle, every o_C[x] = 0x0000001F.
REQ-029 SHALL pass: lane data = its address, grant toggling 1,0,1,0 -> 25 accepted reads in order, o_C[0] = 0x14, o_done delayed by 24 cycles versus REQ-023.
REQ-030 SHALL pass: i_start held high for the whole run -> exactly one run per IDLE visit, no address repeated within a run.
REQ-031 SHALL pass: i_rst_n pulsed low after address 12 is accepted -> outputs all 0 at once, no o_done; a new run then gives correct o_C.
REQ-032 SHALL pass: back-to-back runs with all lanes 0xFFFFFFFF then all lanes 0 -> first o_C[x] = 0xFFFFFFFF, second o_C[x] = 0 (cleared at start).
REQ-033 SHALL pass: i_rd_data = 0xDEADBEEF driven in cycles with no accepted read -> o_C unaffected.
